// File: rtl/mix_output_controller_pkg.sv
// Shared constants for the mix output controller: dimensions, pipeline state codes, FSM states.
package mix_output_controller_pkg;

   localparam int unsigned HID_DIM   = 4;
   localparam int unsigned N_LEN     = 8;
   localparam int unsigned STATE_LEN = 4;

   localparam logic [STATE_LEN-1:0] MIX1 = 4'd3;
   localparam logic [STATE_LEN-1:0] MIX2 = 4'd4;
   localparam logic [STATE_LEN-1:0] MIX3 = 4'd5;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCollect = 2'd1,
      StHold    = 2'd2
   } moc_state_e;

   function automatic logic is_mix(input logic [STATE_LEN-1:0] s);
      return (s == MIX1) || (s == MIX2) || (s == MIX3);
   endfunction

endpackage

// File: rtl/mix_out_transpose.sv
// Combinational reorder of the collected matrix; optional negative clamp on transposed
// layers when MIX_OUT_RELU_EN is defined.
module mix_out_transpose #(
   parameter int unsigned DIM = 4,
   parameter int unsigned DW  = 8
) (
   input  logic [DIM*DIM*DW-1:0] mat,
   input  logic                  transpose,
   output logic [DIM*DIM*DW-1:0] q
);

   always_comb begin
      q = '0;
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            q[(r*DIM+c)*DW +: DW] = transpose ? mat[(c*DIM+r)*DW +: DW]
                                              : mat[(r*DIM+c)*DW +: DW];
`ifdef MIX_OUT_RELU_EN
            if (transpose && q[(r*DIM+c)*DW + DW - 1]) begin
               q[(r*DIM+c)*DW +: DW] = '0;
            end
`endif
         end
      end
   end

endmodule

// File: rtl/mix_output_controller.sv
// Collects DIM result rows, reorders them per latched layer and hands the matrix downstream.
// Optional clamp of negative elements on MIX1/MIX2 via MIX_OUT_RELU_EN.
module mix_output_controller
   import mix_output_controller_pkg::*;
#(
   parameter int unsigned DIM = HID_DIM,
   parameter int unsigned DW  = N_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STATE_LEN-1:0]  state,
   input  logic [DIM*DW-1:0]     d,
   input  logic                  valid_in,
   output logic                  ready_in,
   output logic [DIM*DIM*DW-1:0] q,
   output logic                  valid,
   input  logic                  ready
);

   localparam int unsigned CW = (DIM > 1) ? $clog2(DIM) : 1;

   moc_state_e             fsm_q, fsm_d;
   logic [CW-1:0]          row_cnt_q, row_cnt_d;
   logic [STATE_LEN-1:0]   layer_q, layer_d;
   logic [DIM*DIM*DW-1:0]  buf_q, buf_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q     <= StIdle;
         row_cnt_q <= '0;
         layer_q   <= '0;
         buf_q     <= '0;
      end else begin
         fsm_q     <= fsm_d;
         row_cnt_q <= row_cnt_d;
         layer_q   <= layer_d;
         buf_q     <= buf_d;
      end
   end

   always_comb begin
      fsm_d     = fsm_q;
      row_cnt_d = row_cnt_q;
      layer_d   = layer_q;
      buf_d     = buf_q;
      ready_in  = 1'b0;
      valid     = 1'b0;
      unique case (fsm_q)
         StIdle: begin
            if (is_mix(state)) begin
               fsm_d     = StCollect;
               layer_d   = state;
               row_cnt_d = '0;
            end
         end
         StCollect: begin
            ready_in = 1'b1;
            // A layer change aborts the matrix; a row arriving in the same cycle is dropped.
            if (state != layer_q) begin
               fsm_d     = StIdle;
               row_cnt_d = '0;
            end else if (valid_in) begin
               for (int r = 0; r < DIM; r++) begin
                  if (row_cnt_q == CW'(r)) begin
                     buf_d[r*DIM*DW +: DIM*DW] = d;
                  end
               end
               if (row_cnt_q == CW'(DIM - 1)) begin
                  row_cnt_d = '0;
                  fsm_d     = StHold;
               end else begin
                  row_cnt_d = row_cnt_q + CW'(1);
               end
            end
         end
         StHold: begin
            valid = 1'b1;
            if (ready) begin
               fsm_d = StIdle;
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   mix_out_transpose #(
      .DIM (DIM),
      .DW  (DW)
   ) u_transpose (
      .mat       (buf_q),
      .transpose (layer_q != MIX3),
      .q         (q)
   );

endmodule

// File: tb/tb_mix_output_controller.sv
// Directed + randomized bench for mix_output_controller (DIM=4, DW=8) with a matrix-level model.
module tb_mix_output_controller;
   import mix_output_controller_pkg::*;

   localparam int DIM = 4;
   localparam int DW  = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [STATE_LEN-1:0]  state;
   logic [DIM*DW-1:0]     d;
   logic                  valid_in;
   logic                  ready_in;
   logic [DIM*DIM*DW-1:0] q;
   logic                  valid;
   logic                  ready;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] rows [4][4];

   always #5 clk = ~clk;

   mix_output_controller #(
      .DIM (DIM),
      .DW  (DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .state    (state),
      .d        (d),
      .valid_in (valid_in),
      .ready_in (ready_in),
      .q        (q),
      .valid    (valid),
      .ready    (ready)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] el(input logic [127:0] m, input int r, input int c);
      return m[(r*4+c)*8 +: 8];
   endfunction

   // Reference: matrix as seen downstream, straight from the layer rules.
   function automatic logic [127:0] model(input logic [STATE_LEN-1:0] lay);
      logic [127:0] m;
      logic [7:0]   e;
      m = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            e = (lay == MIX3) ? rows[r][c] : rows[c][r];
`ifdef MIX_OUT_RELU_EN
            if (lay != MIX3 && e[7]) e = 8'h00;
`endif
            m[(r*4+c)*8 +: 8] = e;
         end
      end
      return m;
   endfunction

   function automatic logic [31:0] row_vec(input int r);
      return {rows[r][3], rows[r][2], rows[r][1], rows[r][0]};
   endfunction

   task automatic go_idle();
      state    = 4'd0;
      valid_in = 1'b0;
      step();
      step();
   endtask

   // Feed nrows rows; the last one lands the FSM in HOLD when nrows==4.
   task automatic collect(input logic [STATE_LEN-1:0] lay, input int nrows);
      state = lay;
      step();
      for (int r = 0; r < nrows; r++) begin
         d        = row_vec(r);
         valid_in = 1'b1;
         check("ready_in_collect", {127'd0, ready_in}, 128'd1);
         check("valid_early", {127'd0, valid}, 128'd0);
         step();
      end
      valid_in = 1'b0;
   endtask

   task automatic fill_incr();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            rows[r][c] = 8'(16*r + c);
   endtask

   task automatic fill_rand();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            rows[r][c] = 8'($urandom_range(0, 255));
   endtask

   logic [127:0]         snap;
   logic [STATE_LEN-1:0] lay;

   initial begin
      rst = 1'b1; state = '0; d = '0; valid_in = 1'b0; ready = 1'b0;
      step();
      step();
      check("rst_valid", {127'd0, valid}, 128'd0);
      check("rst_ready_in", {127'd0, ready_in}, 128'd0);
      check("rst_q", q, 128'd0);
      rst = 1'b0;
      step();

      // MIX3 pass-through
      fill_incr();
      collect(MIX3, 4);
      check("mix3_valid", {127'd0, valid}, 128'd1);
      check("mix3_q23", {120'd0, el(q, 2, 3)}, 128'h23);
      check("mix3_q", q, model(MIX3));

      // Backpressure in HOLD, with state moved away
      snap  = q;
      state = 4'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", {127'd0, valid}, 128'd1);
         check("bp_ready_in", {127'd0, ready_in}, 128'd0);
         check("bp_q_stable", q, snap);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      check("bp_release_valid", {127'd0, valid}, 128'd0);
      step();
      check("idle_ready_in", {127'd0, ready_in}, 128'd0);

      // MIX1 transpose
      go_idle();
      collect(MIX1, 4);
      check("mix1_valid", {127'd0, valid}, 128'd1);
      check("mix1_q23", {120'd0, el(q, 2, 3)}, 128'h32);
      check("mix1_q01", {120'd0, el(q, 0, 1)}, 128'h10);
      check("mix1_q", q, model(MIX1));
      ready = 1'b1;
      step();
      ready = 1'b0;
      check("mix1_release", {127'd0, valid}, 128'd0);

      // Randomized matrices, layers and backpressure
      for (int it = 0; it < 12; it++) begin
         go_idle();
         fill_rand();
         case ($urandom_range(0, 2))
            0:       lay = MIX1;
            1:       lay = MIX2;
            default: lay = MIX3;
         endcase
         collect(lay, 4);
         check("rand_valid", {127'd0, valid}, 128'd1);
         check("rand_q", q, model(lay));
         for (int w = $urandom_range(0, 3); w > 0; w--) begin
            step();
            check("rand_hold", {127'd0, valid}, 128'd1);
         end
         ready = 1'b1;
         step();
         ready = 1'b0;
         check("rand_release", {127'd0, valid}, 128'd0);
      end

      // Abort after 2 rows; coinciding row is dropped
      go_idle();
      fill_rand();
      collect(MIX2, 2);
      d        = row_vec(2);
      valid_in = 1'b1;
      state    = 4'd0;
      step();
      valid_in = 1'b0;
      check("abort_valid", {127'd0, valid}, 128'd0);
      check("abort_ready_in", {127'd0, ready_in}, 128'd0);
      step();
      check("abort_valid2", {127'd0, valid}, 128'd0);
      fill_rand();
      collect(MIX2, 4);
      check("reentry_valid", {127'd0, valid}, 128'd1);
      check("reentry_q", q, model(MIX2));
      ready = 1'b1;
      step();
      ready = 1'b0;

      // Clamp behaviour: 0x80 and 0x7F under MIX2 then MIX3
      go_idle();
      fill_incr();
      rows[0][0] = 8'h80;
      rows[0][1] = 8'h7F;
      collect(MIX2, 4);
`ifdef MIX_OUT_RELU_EN
      check("relu_neg", {120'd0, el(q, 0, 0)}, 128'h00);
`else
      check("relu_neg", {120'd0, el(q, 0, 0)}, 128'h80);
`endif
      check("relu_pos", {120'd0, el(q, 1, 0)}, 128'h7F);
      check("relu_q", q, model(MIX2));
      ready = 1'b1;
      step();
      ready = 1'b0;
      go_idle();
      collect(MIX3, 4);
      check("mix3_neg_kept", {120'd0, el(q, 0, 0)}, 128'h80);
      check("mix3_pos_kept", {120'd0, el(q, 0, 1)}, 128'h7F);

      // Reset while in HOLD
      rst = 1'b1;
      step();
      check("rst_hold_valid", {127'd0, valid}, 128'd0);
      check("rst_hold_ready_in", {127'd0, ready_in}, 128'd0);
      check("rst_hold_q", q, 128'd0);
      rst   = 1'b0;
      state = 4'd0;
      step();
      check("rst_hold_idle", {127'd0, ready_in}, 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
